// File: rtl/tlb_cmd_ctrl_if.sv
// Bundle of the command, TLB-array and CSR-response signals around tlb_cmd_ctrl.
// The slave modport is the controller's view; the master modport is the surrounding pipeline/array/CSR view.
interface tlb_cmd_ctrl_if #(
  parameter int TLBNUM = 16,
  parameter int ENTW   = 89
);
  localparam int IW = $clog2(TLBNUM);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both 1;
  // the sender keeps valid and its payload stable until that edge, and ready may not
  // depend combinationally on valid.
  logic            req_valid;
  logic            req_ready;
  logic [2:0]      req_op;
  logic [IW-1:0]   req_index;
  logic [ENTW-1:0] req_entry;
  logic [18:0]     req_vppn;
  logic [9:0]      req_asid;
  logic [4:0]      req_inv_op;

  logic [18:0]     tlb_s_vppn;
  logic [9:0]      tlb_s_asid;
  logic            tlb_s_found;
  logic [IW-1:0]   tlb_s_index;
  logic [IW-1:0]   tlb_r_index;
  logic [ENTW-1:0] tlb_r_entry;
  logic            tlb_we;
  logic [IW-1:0]   tlb_w_index;
  logic [ENTW-1:0] tlb_w_entry;
  logic            invtlb_valid;
  logic [4:0]      invtlb_op;

  logic            resp_valid;
  logic            resp_ready;
  logic [2:0]      resp_op;
  logic            resp_found;
  logic [IW-1:0]   resp_index;
  logic [ENTW-1:0] resp_entry;
  logic            resp_err;

  logic [1:0]      dbg_state;

  modport slave (
    input  req_valid, req_op, req_index, req_entry, req_vppn, req_asid, req_inv_op,
    output req_ready,
    output tlb_s_vppn, tlb_s_asid, tlb_r_index, tlb_we, tlb_w_index, tlb_w_entry,
    output invtlb_valid, invtlb_op,
    input  tlb_s_found, tlb_s_index, tlb_r_entry,
    output resp_valid, resp_op, resp_found, resp_index, resp_entry, resp_err,
    input  resp_ready,
    output dbg_state
  );

  modport master (
    output req_valid, req_op, req_index, req_entry, req_vppn, req_asid, req_inv_op,
    input  req_ready,
    input  tlb_s_vppn, tlb_s_asid, tlb_r_index, tlb_we, tlb_w_index, tlb_w_entry,
    input  invtlb_valid, invtlb_op,
    output tlb_s_found, tlb_s_index, tlb_r_entry,
    input  resp_valid, resp_op, resp_found, resp_index, resp_entry, resp_err,
    output resp_ready,
    input  dbg_state
  );
endinterface

// File: rtl/tlb_cmd_ctrl.sv
// Sequencer for TLBSRCH/TLBRD/TLBWR/TLBFILL/INVTLB: accept, drive the array for one cycle,
// then hold the result until the CSR side takes it. Also owns the free-running fill counter.
module tlb_cmd_ctrl #(
  parameter int TLBNUM = 16,
  parameter int ENTW   = 89
) (
  input logic          clk,
  input logic          resetn,
  tlb_cmd_ctrl_if.slave bus
);
  localparam int IW = $clog2(TLBNUM);

  localparam logic [2:0] OP_SRCH = 3'd1;
  localparam logic [2:0] OP_RD   = 3'd2;
  localparam logic [2:0] OP_WR   = 3'd3;
  localparam logic [2:0] OP_FILL = 3'd4;
  localparam logic [2:0] OP_INV  = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RESP  = 2'd2
  } state_e;

  state_e          state_q;
  logic [IW-1:0]   fill_cnt_q, fill_cnt_d;
  logic [2:0]      op_q;
  logic [IW-1:0]   idx_q;
  logic            err_q;
  logic            illegal_c;

  logic            req_ready_q;
  logic [18:0]     s_vppn_q;
  logic [9:0]      s_asid_q;
  logic [IW-1:0]   r_index_q;
  logic            we_q;
  logic [IW-1:0]   w_index_q;
  logic [ENTW-1:0] w_entry_q;
  logic            inv_valid_q;
  logic [4:0]      inv_op_q;
  logic            resp_valid_q;
  logic [2:0]      resp_op_q;
  logic            resp_found_q;
  logic [IW-1:0]   resp_index_q;
  logic [ENTW-1:0] resp_entry_q;
  logic            resp_err_q;

  always_comb begin
    fill_cnt_d = (fill_cnt_q == IW'(TLBNUM - 1)) ? '0 : fill_cnt_q + 1'b1;
    illegal_c  = (bus.req_op < OP_SRCH) || (bus.req_op > OP_INV) ||
                 ((bus.req_op == OP_INV) && (bus.req_inv_op > 5'd6));
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      fill_cnt_q   <= '0;
      op_q         <= '0;
      idx_q        <= '0;
      err_q        <= 1'b0;
      req_ready_q  <= 1'b1;
      s_vppn_q     <= '0;
      s_asid_q     <= '0;
      r_index_q    <= '0;
      we_q         <= 1'b0;
      w_index_q    <= '0;
      w_entry_q    <= '0;
      inv_valid_q  <= 1'b0;
      inv_op_q     <= '0;
      resp_valid_q <= 1'b0;
      resp_op_q    <= '0;
      resp_found_q <= 1'b0;
      resp_index_q <= '0;
      resp_entry_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      fill_cnt_q <= fill_cnt_d;
      case (state_q)
        S_IDLE: begin
          if (bus.req_valid) begin
            state_q     <= S_ISSUE;
            req_ready_q <= 1'b0;
            op_q        <= bus.req_op;
            err_q       <= illegal_c;
            if (bus.req_op == OP_FILL)
              idx_q <= fill_cnt_q;
            else if ((bus.req_op == OP_RD) || (bus.req_op == OP_WR))
              idx_q <= bus.req_index;
            else
              idx_q <= '0;
            // Port drive for the ISSUE cycle is registered here so it appears exactly then.
            if (!illegal_c) begin
              case (bus.req_op)
                OP_SRCH: begin
                  s_vppn_q <= bus.req_vppn;
                  s_asid_q <= bus.req_asid;
                end
                OP_RD: r_index_q <= bus.req_index;
                OP_WR, OP_FILL: begin
                  we_q      <= 1'b1;
                  w_index_q <= (bus.req_op == OP_FILL) ? fill_cnt_q : bus.req_index;
                  w_entry_q <= bus.req_entry;
                end
                OP_INV: begin
                  inv_valid_q <= 1'b1;
                  inv_op_q    <= bus.req_inv_op;
                  s_vppn_q    <= bus.req_vppn;
                  s_asid_q    <= bus.req_asid;
                end
                default: ;
              endcase
            end
          end
        end
        S_ISSUE: begin
          state_q      <= S_RESP;
          s_vppn_q     <= '0;
          s_asid_q     <= '0;
          r_index_q    <= '0;
          we_q         <= 1'b0;
          w_index_q    <= '0;
          w_entry_q    <= '0;
          inv_valid_q  <= 1'b0;
          inv_op_q     <= '0;
          resp_valid_q <= 1'b1;
          resp_op_q    <= op_q;
          resp_err_q   <= err_q;
          resp_found_q <= 1'b0;
          resp_index_q <= idx_q;
          resp_entry_q <= '0;
          if (!err_q) begin
            if (op_q == OP_SRCH) begin
              resp_found_q <= bus.tlb_s_found;
              resp_index_q <= bus.tlb_s_index;
            end else if ((op_q == OP_RD) && bus.tlb_r_entry[ENTW-1]) begin
              // An invalid entry reads back as all zero with found clear.
              resp_found_q <= 1'b1;
              resp_entry_q <= bus.tlb_r_entry;
            end
          end
        end
        S_RESP: begin
          if (bus.resp_ready) begin
            state_q      <= S_IDLE;
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready    = req_ready_q;
  assign bus.tlb_s_vppn   = s_vppn_q;
  assign bus.tlb_s_asid   = s_asid_q;
  assign bus.tlb_r_index  = r_index_q;
  assign bus.tlb_we       = we_q;
  assign bus.tlb_w_index  = w_index_q;
  assign bus.tlb_w_entry  = w_entry_q;
  assign bus.invtlb_valid = inv_valid_q;
  assign bus.invtlb_op    = inv_op_q;
  assign bus.resp_valid   = resp_valid_q;
  assign bus.resp_op      = resp_op_q;
  assign bus.resp_found   = resp_found_q;
  assign bus.resp_index   = resp_index_q;
  assign bus.resp_entry   = resp_entry_q;
  assign bus.resp_err     = resp_err_q;
  assign bus.dbg_state    = state_q;
endmodule

// File: tb/tb_tlb_cmd_ctrl.sv
// Directed bench for tlb_cmd_ctrl with a small behavioural TLB array behind it.
module tb_tlb_cmd_ctrl;
  localparam int ENTW = 89;

  logic clk;
  logic resetn;
  int   checks = 0;
  int   errors = 0;
  int   cyc;

  tlb_cmd_ctrl_if #(.TLBNUM(16), .ENTW(ENTW)) bus ();
  tlb_cmd_ctrl #(.TLBNUM(16), .ENTW(ENTW)) dut (.clk(clk), .resetn(resetn), .bus(bus));

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge resetn)
    if (!resetn) cyc <= 0;
    else         cyc <= cyc + 1;

  // ---------------- behavioural TLB array ----------------
  logic [ENTW-1:0] arr [16];

  function automatic logic [ENTW-1:0] mk(input logic e, input logic [5:0] ps, input logic [18:0] vppn,
                                         input logic [9:0] asid, input logic g);
    mk = {e, ps, vppn, asid, g, 20'h0abcd, 2'd3, 2'd1, 1'b1, 1'b1, 20'h54321, 2'd0, 2'd2, 1'b0, 1'b1};
  endfunction

  always_comb begin
    bus.tlb_s_found = 1'b0;
    bus.tlb_s_index = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (arr[i][88] && arr[i][81:63] == bus.tlb_s_vppn &&
          (arr[i][52] || arr[i][62:53] == bus.tlb_s_asid)) begin
        bus.tlb_s_found = 1'b1;
        bus.tlb_s_index = 4'(i);
      end
    end
    bus.tlb_r_entry = arr[bus.tlb_r_index];
  end

  always @(posedge clk) begin
    if (bus.tlb_we) arr[bus.tlb_w_index] <= bus.tlb_w_entry;
    if (bus.invtlb_valid) begin
      for (int i = 0; i < 16; i++) begin
        logic g, am, vm, hit;
        g   = arr[i][52];
        am  = (arr[i][62:53] == bus.tlb_s_asid);
        vm  = (arr[i][81:63] == bus.tlb_s_vppn);
        case (bus.invtlb_op)
          5'd0, 5'd1: hit = 1'b1;
          5'd2:       hit = g;
          5'd3:       hit = !g;
          5'd4:       hit = !g && am;
          5'd5:       hit = !g && am && vm;
          5'd6:       hit = (g || am) && vm;
          default:    hit = 1'b0;
        endcase
        if (hit) arr[i][88] <= 1'b0;
      end
    end
  end

  always @(negedge clk)
    if (bus.tlb_we && bus.invtlb_valid) begin
      errors++;
      $display("FAIL strobe_excl: tlb_we and invtlb_valid both 1 at %0t", $time);
    end

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  logic            g_found, g_err, g_rdy_after, g_rv_after;
  logic [2:0]      g_op;
  logic [3:0]      g_index, g_w_index;
  logic [ENTW-1:0] g_entry, g_w_entry;
  logic [4:0]      g_inv_op;
  logic [18:0]     g_s_vppn;
  int              g_we, g_inv, g_lat;

  // ---------------- driver ----------------
  task automatic drive_req(input logic [2:0] op, input logic [3:0] idx, input logic [ENTW-1:0] ent,
                           input logic [18:0] vppn, input logic [9:0] asid, input logic [4:0] iop);
    bus.req_op = op; bus.req_index = idx; bus.req_entry = ent;
    bus.req_vppn = vppn; bus.req_asid = asid; bus.req_inv_op = iop;
    bus.req_valid = 1'b1;
  endtask

  task automatic run_cmd(input logic [2:0] op, input logic [3:0] idx, input logic [ENTW-1:0] ent,
                         input logic [18:0] vppn, input logic [9:0] asid, input logic [4:0] iop);
    int n;
    drive_req(op, idx, ent, vppn, asid, iop);
    n = 0;
    while (!bus.req_ready && n < 20) begin @(negedge clk); n++; end
    chk("accept_timeout", 128'(bus.req_ready), 128'(1'b1));
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    g_we = 0; g_inv = 0; g_w_index = '0; g_w_entry = '0; g_inv_op = '0; g_s_vppn = '0;
    n = 1;
    while (!bus.resp_valid && n < 20) begin
      if (bus.tlb_we) begin g_we++; g_w_index = bus.tlb_w_index; g_w_entry = bus.tlb_w_entry; end
      if (bus.invtlb_valid) begin g_inv++; g_inv_op = bus.invtlb_op; g_s_vppn = bus.tlb_s_vppn; end
      @(negedge clk);
      n++;
    end
    g_lat = n;
    chk("resp_timeout", 128'(bus.resp_valid), 128'(1'b1));
    g_op = bus.resp_op; g_found = bus.resp_found; g_index = bus.resp_index;
    g_entry = bus.resp_entry; g_err = bus.resp_err;
    bus.resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.resp_ready = 1'b0;
    g_rdy_after = bus.req_ready;
    g_rv_after  = bus.resp_valid;
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [2:0]      op;
    logic [3:0]      idx;
    logic [ENTW-1:0] entry;
    logic [18:0]     vppn;
    logic [9:0]      asid;
    logic [4:0]      inv_op;
    logic            exp_found;
    logic [3:0]      exp_index;
    logic [ENTW-1:0] exp_entry;
    logic            exp_err;
    int              exp_we;
    int              exp_inv;
  } vec_t;

  function automatic vec_t v(input logic [2:0] op, input logic [3:0] idx, input logic [ENTW-1:0] ent,
                             input logic [18:0] vppn, input logic [9:0] asid, input logic [4:0] iop,
                             input logic f, input logic [3:0] ri, input logic [ENTW-1:0] re,
                             input logic er, input int we, input int inv);
    v = '{op, idx, ent, vppn, asid, iop, f, ri, re, er, we, inv};
  endfunction

  vec_t tbl [19];
  logic [ENTW-1:0] e5, e2, e3, ef, ew, snap_entry;
  logic [3:0]      snap_index;
  int              hold_we, seen_rv;

  initial begin
    e5 = mk(1'b1, 6'd12, 19'h12345, 10'h3, 1'b0);
    e2 = mk(1'b1, 6'd12, 19'h00abc, 10'h9, 1'b1);
    e3 = mk(1'b1, 6'd12, 19'h33333, 10'h7, 1'b0);
    ef = mk(1'b1, 6'd12, 19'h0f0f0, 10'h1, 1'b0);
    ew = mk(1'b1, 6'd12, 19'h66666, 10'h2, 1'b0);
    for (int i = 0; i < 16; i++) arr[i] = '0;
    arr[7] = mk(1'b0, 6'd12, 19'h7aaaa, 10'h155, 1'b1);

    //            op    idx    entry vppn      asid    iop    fnd  ridx  rentry err we inv
    tbl[0]  = v(3'd3, 4'd5, e5,  19'h0,     10'h0,  5'd0,  0,   4'd5, '0,    0,  1, 0);
    tbl[1]  = v(3'd1, 4'd0, '0,  19'h12345, 10'h3,  5'd0,  1,   4'd5, '0,    0,  0, 0);
    tbl[2]  = v(3'd2, 4'd7, '0,  19'h0,     10'h0,  5'd0,  0,   4'd7, '0,    0,  0, 0);
    tbl[3]  = v(3'd2, 4'd5, '0,  19'h0,     10'h0,  5'd0,  1,   4'd5, e5,    0,  0, 0);
    tbl[4]  = v(3'd3, 4'd2, e2,  19'h0,     10'h0,  5'd0,  0,   4'd2, '0,    0,  1, 0);
    tbl[5]  = v(3'd1, 4'd0, '0,  19'h00abc, 10'h1,  5'd0,  1,   4'd2, '0,    0,  0, 0);
    tbl[6]  = v(3'd1, 4'd0, '0,  19'h7ffff, 10'h3,  5'd0,  0,   4'd0, '0,    0,  0, 0);
    tbl[7]  = v(3'd5, 4'd9, '0,  19'h12345, 10'h3,  5'd5,  0,   4'd0, '0,    0,  0, 1);
    tbl[8]  = v(3'd1, 4'd0, '0,  19'h12345, 10'h3,  5'd0,  0,   4'd0, '0,    0,  0, 0);
    tbl[9]  = v(3'd5, 4'd0, '0,  19'h12345, 10'h3,  5'd7,  0,   4'd0, '0,    1,  0, 0);
    tbl[10] = v(3'd0, 4'd3, e5,  19'h0,     10'h0,  5'd0,  0,   4'd0, '0,    1,  0, 0);
    tbl[11] = v(3'd6, 4'd5, e5,  19'h12345, 10'h3,  5'd0,  0,   4'd0, '0,    1,  0, 0);
    tbl[12] = v(3'd5, 4'd0, '0,  19'h11111, 10'h55, 5'd6,  0,   4'd0, '0,    0,  0, 1);
    tbl[13] = v(3'd1, 4'd0, '0,  19'h00abc, 10'h1,  5'd0,  1,   4'd2, '0,    0,  0, 0);
    tbl[14] = v(3'd5, 4'd0, '0,  19'h0,     10'h0,  5'd2,  0,   4'd0, '0,    0,  0, 1);
    tbl[15] = v(3'd1, 4'd0, '0,  19'h00abc, 10'h1,  5'd0,  0,   4'd0, '0,    0,  0, 0);
    tbl[16] = v(3'd7, 4'd1, e5,  19'h12345, 10'h3,  5'd0,  0,   4'd0, '0,    1,  0, 0);
    tbl[17] = v(3'd5, 4'd0, '0,  19'h12345, 10'h3,  5'd31, 0,   4'd0, '0,    1,  0, 0);
    tbl[18] = v(3'd2, 4'd5, '0,  19'h0,     10'h0,  5'd0,  0,   4'd5, '0,    0,  0, 0);

    bus.req_valid = 1'b0; bus.req_op = '0; bus.req_index = '0; bus.req_entry = '0;
    bus.req_vppn = '0; bus.req_asid = '0; bus.req_inv_op = '0; bus.resp_ready = 1'b0;
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);

    chk("rst_req_ready", 128'(bus.req_ready), 128'(1'b1));
    chk("rst_state", 128'(bus.dbg_state), 128'(2'd0));
    chk("rst_resp_valid", 128'(bus.resp_valid), 128'(1'b0));
    chk("rst_tlb_we", 128'(bus.tlb_we), 128'(1'b0));
    chk("rst_invtlb_valid", 128'(bus.invtlb_valid), 128'(1'b0));
    chk("rst_resp_index", 128'(bus.resp_index), 128'(4'd0));

    for (int i = 0; i < 19; i++) begin
      run_cmd(tbl[i].op, tbl[i].idx, tbl[i].entry, tbl[i].vppn, tbl[i].asid, tbl[i].inv_op);
      chk($sformatf("v%0d_op", i), 128'(g_op), 128'(tbl[i].op));
      chk($sformatf("v%0d_found", i), 128'(g_found), 128'(tbl[i].exp_found));
      chk($sformatf("v%0d_index", i), 128'(g_index), 128'(tbl[i].exp_index));
      chk($sformatf("v%0d_entry", i), 128'(g_entry), 128'(tbl[i].exp_entry));
      chk($sformatf("v%0d_err", i), 128'(g_err), 128'(tbl[i].exp_err));
      chk($sformatf("v%0d_we_cnt", i), 128'(g_we), 128'(tbl[i].exp_we));
      chk($sformatf("v%0d_inv_cnt", i), 128'(g_inv), 128'(tbl[i].exp_inv));
      chk($sformatf("v%0d_latency", i), 128'(g_lat), 128'(2));
      chk($sformatf("v%0d_ready_after", i), 128'(g_rdy_after), 128'(1'b1));
      chk($sformatf("v%0d_rvalid_after", i), 128'(g_rv_after), 128'(1'b0));
      if (tbl[i].exp_we != 0) begin
        chk($sformatf("v%0d_w_index", i), 128'(g_w_index), 128'(tbl[i].idx));
        chk($sformatf("v%0d_w_entry", i), 128'(g_w_entry), 128'(tbl[i].entry));
      end
      if (tbl[i].exp_inv != 0) begin
        chk($sformatf("v%0d_inv_op", i), 128'(g_inv_op), 128'(tbl[i].inv_op));
        chk($sformatf("v%0d_inv_vppn", i), 128'(g_s_vppn), 128'(tbl[i].vppn));
      end
    end

    // Backpressure: RD held for 10 cycles with a competing WR request that must be ignored.
    run_cmd(3'd3, 4'd3, e3, '0, '0, '0);
    chk("bp_wr_cnt", 128'(g_we), 128'(1));
    drive_req(3'd2, 4'd3, '0, '0, '0, '0);
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    chk("bp_rvalid", 128'(bus.resp_valid), 128'(1'b1));
    snap_entry = bus.resp_entry;
    snap_index = bus.resp_index;
    chk("bp_entry", 128'(snap_entry), 128'(e3));
    hold_we = 0;
    for (int k = 0; k < 10; k++) begin
      if (k == 3) drive_req(3'd3, 4'd4, e5, '0, '0, '0);
      @(negedge clk);
      if (bus.tlb_we) hold_we++;
      chk($sformatf("bp_hold%0d_rvalid", k), 128'(bus.resp_valid), 128'(1'b1));
      chk($sformatf("bp_hold%0d_entry", k), 128'(bus.resp_entry), 128'(e3));
      chk($sformatf("bp_hold%0d_index", k), 128'(bus.resp_index), 128'(4'd3));
      chk($sformatf("bp_hold%0d_ready", k), 128'(bus.req_ready), 128'(1'b0));
    end
    bus.req_valid = 1'b0;
    chk("bp_no_we", 128'(hold_we), 128'(0));
    bus.resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.resp_ready = 1'b0;
    chk("bp_release_rvalid", 128'(bus.resp_valid), 128'(1'b0));
    chk("bp_release_ready", 128'(bus.req_ready), 128'(1'b1));
    chk("bp_release_state", 128'(bus.dbg_state), 128'(2'd0));
    chk("bp_idx4_untouched", 128'(arr[4]), 128'(0));

    // FILL index follows the free-running counter from reset, wrapping at 16.
    do_reset();
    seen_rv = 0;
    while (cyc != 9 && seen_rv < 100) begin @(negedge clk); seen_rv++; end
    run_cmd(3'd4, 4'd0, ef, '0, '0, '0);
    chk("fill9_w_index", 128'(g_w_index), 128'(4'd9));
    chk("fill9_resp_index", 128'(g_index), 128'(4'd9));
    chk("fill9_we_cnt", 128'(g_we), 128'(1));
    chk("fill9_w_entry", 128'(g_w_entry), 128'(ef));
    chk("fill9_found", 128'(g_found), 128'(1'b0));
    seen_rv = 0;
    while (cyc != 20 && seen_rv < 100) begin @(negedge clk); seen_rv++; end
    run_cmd(3'd4, 4'd0, ef, '0, '0, '0);
    chk("fill20_w_index", 128'(g_w_index), 128'(4'd4));
    chk("fill20_resp_index", 128'(g_index), 128'(4'd4));

    // Reset asserted during ISSUE of a WR drops the strobe and discards the command.
    @(negedge clk);
    drive_req(3'd3, 4'd6, ew, '0, '0, '0);
    @(posedge clk);
    #1;
    chk("rstmid_we_before", 128'(bus.tlb_we), 128'(1'b1));
    #1;
    resetn = 1'b0;
    #1;
    chk("rstmid_we", 128'(bus.tlb_we), 128'(1'b0));
    chk("rstmid_w_index", 128'(bus.tlb_w_index), 128'(4'd0));
    chk("rstmid_rvalid", 128'(bus.resp_valid), 128'(1'b0));
    chk("rstmid_ready", 128'(bus.req_ready), 128'(1'b1));
    chk("rstmid_state", 128'(bus.dbg_state), 128'(2'd0));
    bus.req_valid = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    seen_rv = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (bus.resp_valid) seen_rv++;
    end
    chk("rstmid_no_resp", 128'(seen_rv), 128'(0));
    chk("rstmid_idle_ready", 128'(bus.req_ready), 128'(1'b1));
    chk("rstmid_idx6_unwritten", 128'(arr[6]), 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
